sd_spi_router: RTL and testbench



---
 rtl/sd_router_pkg.sv | 21 ++
 rtl/spi_cmd_monitor.sv | 85 ++++++++
 rtl/sd_spi_router.sv | 77 +++++++
 tb/tb_sd_spi_router.sv | 200 ++++++++++++++++++++
 4 files changed

// File: rtl/sd_router_pkg.sv
// sd_router_pkg: shared types and constants for the SD SPI router and its command monitor.
package sd_router_pkg;

    typedef enum logic [1:0] {HUNT, ARG, DATA} mon_state_t;

    localparam logic [5:0] CMD_RD1 = 6'd17;
    localparam logic [5:0] CMD_RDM = 6'd18;
    localparam logic [5:0] CMD_WR1 = 6'd24;
    localparam logic [5:0] CMD_WRM = 6'd25;
    localparam logic [1:0] CMD_TOKEN = 2'b01;
    localparam logic [2:0] ARG_BYTES = 3'd5;

    function automatic logic is_wr_cmd(input logic [5:0] c);
        return c == CMD_WR1 || c == CMD_WRM;
    endfunction

    function automatic logic is_data_cmd(input logic [5:0] c);
        return c == CMD_RD1 || c == CMD_RDM || is_wr_cmd(c);
    endfunction

endpackage

// File: rtl/spi_cmd_monitor.sv
// spi_cmd_monitor: synchronizes the SPI bus into clk_sys and decodes SD command tokens.
module spi_cmd_monitor
    import sd_router_pkg::*;
(
    input  logic       clk_sys,
    input  logic       reset,
    input  logic       sck,
    input  logic       mosi,
    input  logic       ss,
    output logic [5:0] last_cmd,
    output logic       cmd_strobe,
    output logic       is_wr,
    output logic       ss_idle
);

    logic [1:0] sck_s, mosi_s, ss_s;
    logic       sck_d, ss_d, sck_rise, byte_done, strobe_d;
    logic [2:0] bit_cnt, byte_cnt, byte_cnt_d;
    logic [6:0] shreg;
    logic [7:0] byte_v;
    logic [5:0] cmd_d;
    mon_state_t state, state_d;

    assign sck_rise  = sck_s[1] & ~sck_d;
    assign byte_v    = {shreg, mosi_s[1]};
    assign byte_done = sck_rise & ~ss_s[1] & (bit_cnt == 3'd7);
    assign ss_idle   = ss_s[1] & ss_d;
    assign is_wr     = cmd_strobe & is_wr_cmd(last_cmd);

    // Synchronizers power up with the bus deselected so selection may switch right away.
    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            sck_s      <= '0;
            mosi_s     <= '0;
            ss_s       <= 2'b11;
            sck_d      <= 1'b0;
            ss_d       <= 1'b1;
            bit_cnt    <= '0;
            shreg      <= '0;
            byte_cnt   <= '0;
            last_cmd   <= '0;
            cmd_strobe <= 1'b0;
            state      <= HUNT;
        end else begin
            sck_s      <= {sck_s[0], sck};
            mosi_s     <= {mosi_s[0], mosi};
            ss_s       <= {ss_s[0], ss};
            sck_d      <= sck_s[1];
            ss_d       <= ss_s[1];
            if (ss_s[1]) bit_cnt <= '0;
            else if (sck_rise) begin
                bit_cnt <= bit_cnt + 3'd1;
                shreg   <= byte_v[6:0];
            end
            byte_cnt   <= byte_cnt_d;
            last_cmd   <= cmd_d;
            cmd_strobe <= strobe_d;
            state      <= state_d;
        end
    end

    always_comb begin
        state_d    = state;
        byte_cnt_d = byte_cnt;
        cmd_d      = last_cmd;
        strobe_d   = 1'b0;
        if (ss_s[1]) state_d = HUNT;
        else if (byte_done) begin
            case (state)
                HUNT: if (byte_v[7:6] == CMD_TOKEN) begin
                    cmd_d      = byte_v[5:0];
                    strobe_d   = 1'b1;
                    byte_cnt_d = '0;
                    state_d    = ARG;
                end
                ARG: begin
                    byte_cnt_d = byte_cnt + 3'd1;
                    if (byte_cnt == ARG_BYTES - 3'd1) state_d = is_data_cmd(last_cmd) ? DATA : HUNT;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/sd_spi_router.sv
// sd_spi_router: routes the core SPI master to the physical or virtual SD card,
// switching only while idle, and derives activity / write-activity LED indications.
module sd_spi_router
    import sd_router_pkg::*;
#(
    parameter int unsigned TIMEOUT = 1000000
) (
    input  logic        clk_sys,
    input  logic        reset,
    input  logic        img_mounted,
    input  logic [63:0] img_size,
    input  logic        spi_sck,
    input  logic        spi_mosi,
    input  logic        spi_ss,
    output logic        spi_miso,
    output logic        sd_sck,
    output logic        sd_mosi,
    output logic        sd_cs,
    input  logic        sd_miso,
    output logic        vsd_ss,
    input  logic        vsd_miso,
    output logic        vsd_sel,
    output logic        act,
    output logic        wr_act,
    output logic [5:0]  last_cmd,
    output logic        cmd_strobe
);

    localparam logic [31:0] TMAX = TIMEOUT;

    logic        pend_sel, is_wr, ss_idle, toggle, act_d;
    logic [31:0] timer;
    logic [2:0]  mo_s, mi_s;

    assign spi_miso = vsd_sel ? vsd_miso : sd_miso;
    assign sd_cs    = vsd_sel | spi_ss;
    assign sd_sck   = spi_sck & ~sd_cs;
    assign sd_mosi  = spi_mosi & ~sd_cs;
    assign vsd_ss   = ~vsd_sel | spi_ss;

    spi_cmd_monitor u_mon (
        .clk_sys    (clk_sys),
        .reset      (reset),
        .sck        (spi_sck),
        .mosi       (spi_mosi),
        .ss         (spi_ss),
        .last_cmd   (last_cmd),
        .cmd_strobe (cmd_strobe),
        .is_wr      (is_wr),
        .ss_idle    (ss_idle)
    );

    assign toggle = (mo_s[2] ^ mo_s[1]) | (mi_s[2] ^ mi_s[1]);
    assign act_d  = timer < TMAX;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            pend_sel <= 1'b0;
            vsd_sel  <= 1'b0;
            mo_s     <= '0;
            mi_s     <= '0;
            timer    <= '0;
            act      <= 1'b0;
            wr_act   <= 1'b0;
        end else begin
            if (img_mounted) pend_sel <= |img_size;
            if (ss_idle) vsd_sel <= pend_sel;
            mo_s   <= {mo_s[1:0], spi_mosi};
            mi_s   <= {mi_s[1:0], spi_miso};
            timer  <= toggle ? '0 : act_d ? timer + 32'd1 : timer;
            act    <= act_d;
            // Write activity lasts until the activity window closes.
            wr_act <= is_wr | (wr_act & ~(act & ~act_d));
        end
    end

endmodule

// File: tb/tb_sd_spi_router.sv
// tb_sd_spi_router: directed stimulus with a queue-based scoreboard for decoded commands.
module tb_sd_spi_router;

    localparam int unsigned TO = 1000;

    logic        clk_sys = 1'b0, reset = 1'b1, img_mounted = 1'b0;
    logic [63:0] img_size = '0;
    logic        spi_sck = 1'b0, spi_mosi = 1'b0, spi_ss = 1'b1, sd_miso = 1'b0, vsd_miso = 1'b0;
    logic        spi_miso, sd_sck, sd_mosi, sd_cs, vsd_ss, vsd_sel, act, wr_act, cmd_strobe;
    logic [5:0]  last_cmd;

    int tests = 0, failed = 0;
    logic [5:0] exp_q[$];

    sd_spi_router #(.TIMEOUT(TO)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .img_mounted (img_mounted),
        .img_size    (img_size),
        .spi_sck     (spi_sck),
        .spi_mosi    (spi_mosi),
        .spi_ss      (spi_ss),
        .spi_miso    (spi_miso),
        .sd_sck      (sd_sck),
        .sd_mosi     (sd_mosi),
        .sd_cs       (sd_cs),
        .sd_miso     (sd_miso),
        .vsd_ss      (vsd_ss),
        .vsd_miso    (vsd_miso),
        .vsd_sel     (vsd_sel),
        .act         (act),
        .wr_act      (wr_act),
        .last_cmd    (last_cmd),
        .cmd_strobe  (cmd_strobe)
    );

    always #5 clk_sys = ~clk_sys;

    task automatic tick(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            failed++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    // Mode-0 byte, SCK period of 8 clk_sys; optional mount pulse during bit mount_bit.
    task automatic send_byte(input logic [7:0] b, input int mount_bit);
        for (int i = 7; i >= 0; i--) begin
            spi_mosi = b[i];
            if (i == mount_bit) begin
                img_mounted = 1'b1;
                tick(1);
                img_mounted = 1'b0;
                tick(3);
            end else tick(4);
            spi_sck = 1'b1;
            tick(4);
            spi_sck = 1'b0;
        end
    endtask

    always @(negedge clk_sys) begin
        if (cmd_strobe) begin
            tests++;
            if (exp_q.size() == 0) begin
                failed++;
                $display("FAIL cmd_strobe_unexpected: got last_cmd %0d expected no strobe", last_cmd);
            end else begin
                automatic logic [5:0] e = exp_q.pop_front();
                if (last_cmd !== e) begin
                    failed++;
                    $display("FAIL cmd_decode: got %0d expected %0d", last_cmd, e);
                end
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        tick(3);
        check("rst_act", act, 0);
        check("rst_vsd_sel", vsd_sel, 0);
        check("rst_wr_act", wr_act, 0);
        check("rst_last_cmd", last_cmd, 0);
        check("rst_strobe", cmd_strobe, 0);
        reset = 1'b0;
        tick(1);
        check("act_powerup", act, 1);
        tick(TO - 1);
        check("act_hold", act, 1);
        tick(1);
        check("act_expire", act, 0);
        check("idle_vsd_sel", vsd_sel, 0);

        spi_ss = 1'b0; spi_sck = 1'b1; spi_mosi = 1'b1; sd_miso = 1'b1; #1;
        check("phys_cs", sd_cs, 0);
        check("phys_sck", sd_sck, 1);
        check("phys_mosi", sd_mosi, 1);
        check("phys_vsd_ss", vsd_ss, 1);
        check("phys_miso", spi_miso, 1);
        spi_ss = 1'b1; #1;
        check("gate_sck", sd_sck, 0);
        check("gate_mosi", sd_mosi, 0);
        spi_sck = 1'b0; spi_mosi = 1'b0; sd_miso = 1'b0;
        tick(4);

        img_size = 64'h100000;
        spi_ss = 1'b0;
        tick(4);
        send_byte(8'hFF, 4);
        tick(2);
        check("sel_mid_xfer", vsd_sel, 0);
        spi_ss = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            tick(1);
            check("sel_hold", vsd_sel, 0);
        end
        tick(3);
        check("sel_switch", vsd_sel, 1);
        spi_ss = 1'b0; #1;
        check("virt_sd_cs", sd_cs, 1);
        check("virt_vsd_ss_low", vsd_ss, 0);
        vsd_miso = 1'b1; #1;
        check("virt_miso", spi_miso, 1);
        vsd_miso = 1'b0; spi_ss = 1'b1; #1;
        check("virt_vsd_ss_high", vsd_ss, 1);
        tick(4);

        spi_ss = 1'b0;
        tick(4);
        exp_q.push_back(6'd17);
        send_byte(8'h51, 8);
        for (int i = 0; i < 4; i++) send_byte(8'h00, 8);
        send_byte(8'hFF, 8);
        send_byte(8'h4A, 8);
        send_byte(8'h55, 8);
        tick(4);
        spi_ss = 1'b1;
        tick(8);
        check("read_wr_act", wr_act, 0);

        spi_ss = 1'b0;
        tick(4);
        send_byte(8'hFF, 8);
        send_byte(8'hFF, 8);
        exp_q.push_back(6'd24);
        send_byte(8'h58, 8);
        tick(4);
        check("wr_last_cmd", last_cmd, 24);
        check("wr_act_set", wr_act, 1);
        spi_ss = 1'b1;
        tick(8);
        check("wr_act_busy", act, 1);
        tick(TO + 10);
        check("quiet_act", act, 0);
        check("quiet_wr_act", wr_act, 0);

        spi_ss = 1'b0;
        tick(4);
        exp_q.push_back(6'd18);
        send_byte(8'h52, 8);
        send_byte(8'h00, 8);
        send_byte(8'h00, 8);
        reset = 1'b1; #1;
        check("arg_rst_vsd_sel", vsd_sel, 0);
        check("arg_rst_act", act, 0);
        check("arg_rst_wr_act", wr_act, 0);
        check("arg_rst_last_cmd", last_cmd, 0);
        check("arg_rst_strobe", cmd_strobe, 0);
        check("arg_rst_sd_cs", sd_cs, 0);
        check("arg_rst_vsd_ss", vsd_ss, 1);
        tick(2);
        reset = 1'b0;
        spi_ss = 1'b1;
        tick(4);
        spi_ss = 1'b0;
        tick(4);
        exp_q.push_back(6'd0);
        send_byte(8'h40, 8);
        tick(4);
        spi_ss = 1'b1;
        tick(8);
        check("cmd0_last_cmd", last_cmd, 0);
        check("queue_empty", exp_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
